// File: rtl/seg7_pkg.sv
// Shared glyph codes and capture FSM encoding for the seven-segment readback path.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0     = 7'h7E;
    localparam logic [6:0] GLYPH_1     = 7'h30;
    localparam logic [6:0] GLYPH_2     = 7'h6D;
    localparam logic [6:0] GLYPH_3     = 7'h79;
    localparam logic [6:0] GLYPH_4     = 7'h33;
    localparam logic [6:0] GLYPH_5     = 7'h5B;
    localparam logic [6:0] GLYPH_6     = 7'h5F;
    localparam logic [6:0] GLYPH_7     = 7'h70;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h7B;
    localparam logic [6:0] GLYPH_A     = 7'h77;
    localparam logic [6:0] GLYPH_B     = 7'h1F;
    localparam logic [6:0] GLYPH_C     = 7'h4E;
    localparam logic [6:0] GLYPH_D     = 7'h3D;
    localparam logic [6:0] GLYPH_E     = 7'h4F;
    localparam logic [6:0] GLYPH_F     = 7'h47;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

endpackage

// File: rtl/seg7_scan_capture_encoder.sv
// Combinational segment-pattern to hex lookup; SEG7_CAPTURE_BLANK_EN adds the all-off blank glyph.
module seg7_glyph_encoder
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_value,
    output logic       o_invalid
`ifdef SEG7_CAPTURE_BLANK_EN
    ,
    output logic       o_blank
`endif
);

    always_comb begin
        o_value   = 4'h0;
        o_invalid = 1'b0;
`ifdef SEG7_CAPTURE_BLANK_EN
        o_blank   = 1'b0;
`endif
        case (i_seg)
            GLYPH_0: o_value = 4'h0;
            GLYPH_1: o_value = 4'h1;
            GLYPH_2: o_value = 4'h2;
            GLYPH_3: o_value = 4'h3;
            GLYPH_4: o_value = 4'h4;
            GLYPH_5: o_value = 4'h5;
            GLYPH_6: o_value = 4'h6;
            GLYPH_7: o_value = 4'h7;
            GLYPH_8: o_value = 4'h8;
            GLYPH_9: o_value = 4'h9;
            GLYPH_A: o_value = 4'hA;
            GLYPH_B: o_value = 4'hB;
            GLYPH_C: o_value = 4'hC;
            GLYPH_D: o_value = 4'hD;
            GLYPH_E: o_value = 4'hE;
            GLYPH_F: o_value = 4'hF;
`ifdef SEG7_CAPTURE_BLANK_EN
            GLYPH_BLANK: o_blank = 1'b1;
`endif
            default: o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples the multiplexed segment bus, waits for a digit to settle, decodes it and reports it.
// Optional SEG7_CAPTURE_BLANK_EN accepts the all-off pattern as a blank glyph and adds o_blank.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS           = 4,
    parameter int SETTLE_CYCLES        = 8,
    parameter int COMMON_ANODE_CATHODE = 0
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [6:0]                      i_seg,
    input  logic [NUM_DIGITS-1:0]           i_dig_en,
    input  logic                            i_ready,
    output logic                            o_valid,
    output logic [$clog2(NUM_DIGITS)-1:0]   o_digit_idx,
    output logic [3:0]                      o_value,
    output logic                            o_invalid,
    output logic [4*NUM_DIGITS-1:0]         o_values,
    output logic                            o_overrun,
    output logic                            o_multi_err
`ifdef SEG7_CAPTURE_BLANK_EN
    ,
    output logic                            o_blank
`endif
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 2);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic                    valid_q, valid_d;
    logic [IW-1:0]           digitIdx_q, digitIdx_d;
    logic [3:0]              value_q, value_d;
    logic                    invalid_q, invalid_d;
    logic [4*NUM_DIGITS-1:0] values_q, values_d;
    logic                    overrun_q, overrun_d;
    logic                    multiErr_q, multiErr_d;

    logic [6:0]    segN;
    logic [IW-1:0] idxNow;
    logic          oneHot;
    logic          samePair;
    logic [3:0]    encValue;
    logic          encInvalid;
    logic          encBlank;

    assign segN     = (COMMON_ANODE_CATHODE != 0) ? i_seg : ~i_seg;
    assign oneHot   = $onehot(i_dig_en);
    assign samePair = oneHot && (idxNow == idx_q) && (segN == seg_q);

    always_comb begin
        idxNow = '0;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (i_dig_en[n]) idxNow = IW'(n);
        end
    end

    // Decode the latched pattern, which is what CAPTURE commits.
    seg7_glyph_encoder u_encoder (
        .i_seg     (seg_q),
        .o_value   (encValue),
        .o_invalid (encInvalid)
`ifdef SEG7_CAPTURE_BLANK_EN
        ,
        .o_blank   (encBlank)
`endif
    );

`ifndef SEG7_CAPTURE_BLANK_EN
    assign encBlank = 1'b0;
`endif

    // Leaving HOLD treats the new sample exactly like IDLE would, so a new digit latches immediately.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        seg_d   = seg_q;
        case (state_q)
            IDLE: begin
                if (oneHot) begin
                    idx_d   = idxNow;
                    seg_d   = segN;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (samePair) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = CAPTURE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (oneHot) begin
                    idx_d = idxNow;
                    seg_d = segN;
                    cnt_d = '0;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            CAPTURE: state_d = HOLD;
            HOLD: begin
                if (!samePair) begin
                    if (oneHot) begin
                        idx_d   = idxNow;
                        seg_d   = segN;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SEG7_CAPTURE_BLANK_EN
    logic blank_q, blank_d;
    assign o_blank = blank_q;
`endif

    // Acceptance is applied first so a capture on the same edge refills the slot without overrun.
    always_comb begin
        valid_d    = valid_q;
        digitIdx_d = digitIdx_q;
        value_d    = value_q;
        invalid_d  = invalid_q;
        values_d   = values_q;
        overrun_d  = overrun_q;
        multiErr_d = multiErr_q | !$onehot0(i_dig_en);
`ifdef SEG7_CAPTURE_BLANK_EN
        blank_d    = blank_q;
`endif
        if (valid_q && i_ready) valid_d = 1'b0;
        if (state_q == CAPTURE) begin
            if (valid_d) begin
                overrun_d = 1'b1;
            end else begin
                valid_d    = 1'b1;
                digitIdx_d = idx_q;
                value_d    = encValue;
                invalid_d  = encInvalid;
`ifdef SEG7_CAPTURE_BLANK_EN
                blank_d    = encBlank;
`endif
            end
            if (!encInvalid && !encBlank) begin
                for (int n = 0; n < NUM_DIGITS; n++) begin
                    if (idx_q == IW'(n)) values_d[4*n +: 4] = encValue;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            seg_q      <= '0;
            valid_q    <= 1'b0;
            digitIdx_q <= '0;
            value_q    <= '0;
            invalid_q  <= 1'b0;
            values_q   <= '0;
            overrun_q  <= 1'b0;
            multiErr_q <= 1'b0;
`ifdef SEG7_CAPTURE_BLANK_EN
            blank_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            valid_q    <= valid_d;
            digitIdx_q <= digitIdx_d;
            value_q    <= value_d;
            invalid_q  <= invalid_d;
            values_q   <= values_d;
            overrun_q  <= overrun_d;
            multiErr_q <= multiErr_d;
`ifdef SEG7_CAPTURE_BLANK_EN
            blank_q    <= blank_d;
`endif
        end
    end

    assign o_valid     = valid_q;
    assign o_digit_idx = digitIdx_q;
    assign o_value     = value_q;
    assign o_invalid   = invalid_q;
    assign o_values    = values_q;
    assign o_overrun   = overrun_q;
    assign o_multi_err = multiErr_q;

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Receive side of the seven-segment interface: samples the multiplexed segment bus (a..g) and the one-hot digit-enable strobes, waits for each digit's pattern to settle, converts the pattern back to a 4-bit hex value, and reports it over a valid/ready handshake. It also keeps a per-digit snapshot register. It sits between the stopwatch display driver outputs and the self-test/readback logic, and closes the loop on the hex-to-segment encoding.

## Interface
Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; must be ≥ 2.
- SETTLE_CYCLES, 8: consecutive identical samples required before a capture; must be ≥ 2.
- COMMON_ANODE_CATHODE, 0: 1 = segments active-high on i_seg; 0 = active-low, and the block inverts them internally.

Ports:
- i_clk  in  1  the single clock; all logic is on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_seg  in  7  segment bus {a,b,c,d,e,f,g}, with a as the MSB.
- i_dig_en  in  NUM_DIGITS  digit enables, active-high, one-hot when valid.
- i_ready  in  1  consumer accepts the report.
- o_valid  out  1  a report is pending.
- o_digit_idx  out  $clog2(NUM_DIGITS)  index of the reported digit.
- o_value  out  4  decoded hex value.
- o_invalid  out  1  the reported pattern is not a legal glyph.
- o_values  out  4*NUM_DIGITS  snapshot; digit n occupies bits [4n+3:4n].
- o_overrun  out  1  sticky: a capture occurred while a report was pending.
- o_multi_err  out  1  sticky: more than one enable was sampled high.

## Operation
- Normalization: seg_n = COMMON_ANODE_CATHODE ? i_seg : ~i_seg.
- Glyph map (seg_n → value):
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7
  - 7F→8, 7B→9, 77→A, 1F→B, 4E→C, 3D→D, 4F→E, 47→F
  - Any other pattern → value 0 with invalid=1.
- FSM states:
  - IDLE: zero or multiple enables are sampled. If multiple, set o_multi_err. When exactly one enable is sampled, latch {idx, seg_n}, clear the counter, and go to SETTLE.
  - SETTLE: each edge whose sample equals the latched pair increments the counter. A differing one-hot sample re-latches and clears the counter. A non-one-hot sample returns the FSM to IDLE. When the counter reaches SETTLE_CYCLES-1, go to CAPTURE.
  - CAPTURE (1 cycle): write the value into o_values[idx], or leave that slot unchanged if invalid. If no report is pending, load o_digit_idx/o_value/o_invalid and set o_valid. Otherwise set o_overrun and keep the pending report unchanged. Then go to HOLD.
  - HOLD: stays here while the sampled pair equals the latched pair, so the same digit is never captured twice. On any change, go to IDLE with the same handling as IDLE for that sample.
- Handshake: o_valid stays high and the report fields stay stable until an edge with o_valid && i_ready. o_valid drops on that edge. A capture in the same cycle as acceptance loads the new report with no overrun.
- Sticky flags clear only on reset.

## Timing
- Inputs go straight into the FSM compare with no input register.
- Latency: a pair held constant from edge k gives o_valid high after edge k+SETTLE_CYCLES, and o_values updates on the same edge.
- A pattern that toggles within fewer than SETTLE_CYCLES edges is never reported.
- Reset (asynchronous, any time, including mid-SETTLE or with a report pending):
  - FSM goes to IDLE and the counter to 0.
  - o_valid, o_digit_idx, o_value, o_invalid, o_values, o_overrun, o_multi_err all go to 0.
  - A pending report is discarded.
- The counter width is $clog2(SETTLE_CYCLES) and it never wraps, because it is cleared on leaving SETTLE.

## Configuration
- SEG7_CAPTURE_BLANK_EN defined:
  - seg_n == 00 is a legal blank glyph.
  - The block adds an output port o_blank (1 bit), which is set with the report and reset to 0.
  - Blank reports carry value 0, invalid=0, blank=1, and o_values is not written.
- Macro undefined: 00 is treated as any other illegal pattern (invalid=1), and the o_blank port does not exist.

## Structure
- Shared package seg7_pkg holds:
  - localparams for the 16 glyph codes and the BLANK code;
  - the FSM state typedef enum {IDLE, SETTLE, CAPTURE, HOLD}.
- Sub-module seg7_glyph_encoder is a combinational 7-bit → {value, invalid, blank} lookup, instantiated once.

## Test plan
- COMMON_ANODE_CATHODE=0, i_dig_en=0010, i_seg=~7'h6D held for 12 cycles, i_ready=1 → one report: idx=1, value=2, invalid=0, o_values[7:4]=2, o_valid high for exactly 1 cycle.
- Pattern 7'h7E alternating with 7'h30 every 4 cycles on digit 0, SETTLE_CYCLES=8 → no o_valid ever.
- i_ready=0; capture digit0=5 (5B), then digit1=A (77) → report remains idx0/5, o_overrun=1, o_values=…A5. After i_ready=1 for one cycle, o_valid drops.
- i_dig_en=0110 → o_multi_err=1 on the next edge and no capture. Then 0100 with pattern 7'h2A held for 10 cycles → invalid=1, value=0, o_values unchanged.
- Assert i_rst mid-SETTLE and again with a report pending → all outputs are 0 immediately. After release, a fresh 8-cycle settle is required.
- With SEG7_CAPTURE_BLANK_EN, pattern 00 on digit 3 → blank=1, invalid=0. Without the macro, the same stimulus → invalid=1.
